bcd_updown_chain: RTL and testbench

Parametrised multi-digit BCD up/down counter for the timer/stopwatch datapath. It generalises the single-digit down counter to DIGITS cascaded digits, each with its own runtime limit. It supports up or down counting, wrap or saturate end behaviour, and synchronous preset load. It sits between the 1 Hz tick generator and the seven-segment display mux, and drives `value` directly into the display path.

---
 rtl/bcd_updown_chain.sv | 112 +++++++++++
 tb/tb_bcd_updown_chain.sv | 114 +++++++++++
 2 files changed

// File: rtl/bcd_updown_chain.sv
// Cascaded BCD up/down counter with per-digit runtime limits, wrap/saturate ends
// and synchronous preset load. Digit 0 is the least significant nibble.
module bcd_updown_chain #(
  parameter int                  DIGITS = 4,
  parameter bit                  WRAP   = 1'b1,
  parameter logic [4*DIGITS-1:0] INIT   = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic [4*DIGITS-1:0] limit,
  input  logic                en,
  input  logic                tick,
  input  logic                up,
  output logic [4*DIGITS-1:0] value,
  output logic                carry,
  output logic                borrow,
  output logic                zero,
  output logic                at_limit
);

  logic [4*DIGITS-1:0] value_q, value_d;
  logic                carry_q, carry_d;
  logic                borrow_q, borrow_d;
  logic [4*DIGITS-1:0] eff;
  logic [4*DIGITS-1:0] up_next, dn_next;

  function automatic logic [3:0] sat9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  function automatic logic [3:0] clamp(input logic [3:0] n, input logic [3:0] e);
    return (n > e) ? e : n;
  endfunction

  always_comb begin
    eff = '0;
    for (int i = 0; i < DIGITS; i++) begin
      eff[4*i +: 4] = sat9(limit[4*i +: 4]);
    end
  end

  assign zero     = (value_q == '0);
  assign at_limit = (value_q == eff);

  // Ripple: a digit moves only when every lower digit is at its end of range.
  always_comb begin : ripple
    logic       all_hi;
    logic       all_lo;
    logic [3:0] d;
    logic [3:0] e;
    up_next = value_q;
    dn_next = value_q;
    all_hi  = 1'b1;
    all_lo  = 1'b1;
    d       = '0;
    e       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = value_q[4*i +: 4];
      e = eff[4*i +: 4];
      if (all_hi) up_next[4*i +: 4] = (d >= e) ? 4'd0 : d + 4'd1;
      if (all_lo) dn_next[4*i +: 4] = (d == 4'd0) ? e : d - 4'd1;
      all_hi = all_hi & (d >= e);
      all_lo = all_lo & (d == 4'd0);
    end
  end

  always_comb begin
    value_d  = value_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        value_d[4*i +: 4] = clamp(load_value[4*i +: 4], eff[4*i +: 4]);
      end
    end else if (en && tick) begin
      if (up) begin
        if (at_limit) begin
          carry_d = 1'b1;
          value_d = WRAP ? '0 : value_q;
        end else begin
          value_d = up_next;
        end
      end else begin
        if (zero) begin
          borrow_d = 1'b1;
          value_d  = WRAP ? eff : value_q;
        end else begin
          value_d = dn_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q  <= INIT;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign value  = value_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_bcd_updown_chain.sv
// Directed bench: a wrapping and a saturating instance share stimulus; expected
// results are queued at drive time and compared one cycle later.
module tb_bcd_updown_chain;

  logic        clk = 1'b0;
  logic        rst, load, en, tick, up;
  logic [15:0] load_value, limit;
  logic [15:0] value_w, value_s;
  logic        carry_w, borrow_w, zero_w, at_limit_w;
  logic        carry_s, borrow_s, zero_s, at_limit_s;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [15:0] vw, vs;
    logic        cw, bw, cs, bs, zw, aw;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_updown_chain #(.DIGITS(4), .WRAP(1'b1), .INIT(16'h0030)) dut_w (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value), .limit(limit),
    .en(en), .tick(tick), .up(up), .value(value_w), .carry(carry_w),
    .borrow(borrow_w), .zero(zero_w), .at_limit(at_limit_w)
  );

  bcd_updown_chain #(.DIGITS(4), .WRAP(1'b0), .INIT(16'h0030)) dut_s (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value), .limit(limit),
    .en(en), .tick(tick), .up(up), .value(value_s), .carry(carry_s),
    .borrow(borrow_s), .zero(zero_s), .at_limit(at_limit_s)
  );

  task automatic chk(input string tag, input string what, input logic [15:0] obs,
                     input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic ld,
                      input logic [15:0] lv, input logic [15:0] lim,
                      input logic e, input logic t, input logic u,
                      input logic [15:0] vw, input logic [15:0] vs,
                      input logic cw, input logic bw, input logic cs,
                      input logic bs, input logic zw, input logic aw);
    exp_t x;
    rst = r; load = ld; load_value = lv; limit = lim; en = e; tick = t; up = u;
    x.tag = tag; x.vw = vw; x.vs = vs; x.cw = cw; x.bw = bw;
    x.cs = cs; x.bs = bs; x.zw = zw; x.aw = aw;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      x = sb.pop_front();
      chk(x.tag, "value_w",  value_w,           x.vw);
      chk(x.tag, "value_s",  value_s,           x.vs);
      chk(x.tag, "carry_w",  {15'd0, carry_w},  {15'd0, x.cw});
      chk(x.tag, "borrow_w", {15'd0, borrow_w}, {15'd0, x.bw});
      chk(x.tag, "carry_s",  {15'd0, carry_s},  {15'd0, x.cs});
      chk(x.tag, "borrow_s", {15'd0, borrow_s}, {15'd0, x.bs});
      chk(x.tag, "zero_w",   {15'd0, zero_w},   {15'd0, x.zw});
      chk(x.tag, "atlim_w",  {15'd0, at_limit_w}, {15'd0, x.aw});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //    tag          rst ld  load_val  limit     en tk up  vw        vs        cw bw cs bs zw aw
    step("reset",      1, 0, 16'h0000, 16'h5959, 0, 0, 0, 16'h0030, 16'h0030, 0, 0, 0, 0, 0, 0);
    step("frozen_up",  0, 0, 16'h0000, 16'h5959, 0, 1, 1, 16'h0030, 16'h0030, 0, 0, 0, 0, 0, 0);
    step("frozen_dn",  0, 0, 16'h0000, 16'h5959, 0, 1, 0, 16'h0030, 16'h0030, 0, 0, 0, 0, 0, 0);
    step("up1",        0, 0, 16'h0000, 16'h5959, 1, 1, 1, 16'h0031, 16'h0031, 0, 0, 0, 0, 0, 0);
    step("load0100",   0, 1, 16'h0100, 16'h5959, 0, 0, 0, 16'h0100, 16'h0100, 0, 0, 0, 0, 0, 0);
    step("dn_ripple",  0, 0, 16'h0000, 16'h5959, 1, 1, 0, 16'h0059, 16'h0059, 0, 0, 0, 0, 0, 0);
    step("load0000",   0, 1, 16'h0000, 16'h5959, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0);
    step("underflow",  0, 0, 16'h0000, 16'h5959, 1, 1, 0, 16'h5959, 16'h0000, 0, 1, 0, 1, 0, 1);
    step("uf_idle",    0, 0, 16'h0000, 16'h5959, 1, 0, 0, 16'h5959, 16'h0000, 0, 0, 0, 0, 0, 1);
    step("uf_again",   0, 0, 16'h0000, 16'h5959, 1, 1, 0, 16'h5958, 16'h0000, 0, 0, 0, 1, 0, 0);
    step("load5959",   0, 1, 16'h5959, 16'h5959, 0, 0, 1, 16'h5959, 16'h5959, 0, 0, 0, 0, 0, 1);
    step("overflow",   0, 0, 16'h0000, 16'h5959, 1, 1, 1, 16'h0000, 16'h5959, 1, 0, 1, 0, 1, 0);
    step("of_idle",    0, 0, 16'h0000, 16'h5959, 1, 0, 1, 16'h0000, 16'h5959, 0, 0, 0, 0, 1, 0);
    step("of_again",   0, 0, 16'h0000, 16'h5959, 1, 1, 1, 16'h0001, 16'h5959, 0, 0, 1, 0, 0, 0);
    step("rst_mid",    1, 0, 16'h0000, 16'h5959, 1, 1, 1, 16'h0030, 16'h0030, 0, 0, 0, 0, 0, 0);
    step("load_prio",  0, 1, 16'hA7F3, 16'h5959, 1, 1, 1, 16'h5753, 16'h5753, 0, 0, 0, 0, 0, 0);
    step("up_after",   0, 0, 16'h0000, 16'h5959, 1, 1, 1, 16'h5754, 16'h5754, 0, 0, 0, 0, 0, 0);
    step("load0959",   0, 1, 16'h0959, 16'h5959, 0, 0, 0, 16'h0959, 16'h0959, 0, 0, 0, 0, 0, 0);
    step("up_ripple",  0, 0, 16'h0000, 16'h5959, 1, 1, 1, 16'h1000, 16'h1000, 0, 0, 0, 0, 0, 0);
    step("load0999",   0, 1, 16'h0999, 16'hFFFF, 0, 0, 0, 16'h0999, 16'h0999, 0, 0, 0, 0, 0, 0);
    step("up_limsat",  0, 0, 16'h0000, 16'hFFFF, 1, 1, 1, 16'h1000, 16'h1000, 0, 0, 0, 0, 0, 0);
    step("load0800",   0, 1, 16'h0800, 16'hFFFF, 0, 0, 0, 16'h0800, 16'h0800, 0, 0, 0, 0, 0, 0);
    step("dn_lowered", 0, 0, 16'h0000, 16'h0505, 1, 1, 0, 16'h0705, 16'h0705, 0, 0, 0, 0, 0, 0);
    step("load0505",   0, 1, 16'h0505, 16'h0505, 0, 0, 0, 16'h0505, 16'h0505, 0, 0, 0, 0, 0, 1);
    step("of_smalllim",0, 0, 16'h0000, 16'h0505, 1, 1, 1, 16'h0000, 16'h0505, 1, 0, 1, 0, 1, 0);
    step("final_idle", 0, 0, 16'h0000, 16'h0505, 0, 0, 0, 16'h0000, 16'h0505, 0, 0, 0, 0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
